// File: rtl/dmem_responder.sv
// Memory-stage data RAM responder with a fixed access latency.
// Handles word and byte loads and stores, and flags misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MemErrM,
  output logic [15:0] AccessCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] access_cnt_q, access_cnt_d;
  logic        complete;
  logic        stall;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic          out_of_range;
  logic          misaligned;
  logic          acc_err;
  logic          done;
  logic          wr_en;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;

  assign widx         = ALUOutM[AW+1:2];
  assign out_of_range = (ALUOutM[31:2] >= 30'(DEPTH));
  assign misaligned   = !ByteM && (ALUOutM[1:0] != 2'b00);
  assign acc_err      = out_of_range || misaligned;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemReqM) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (!MemReqM) begin
          state_d = IDLE;
        end else if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset low masks every output and blocks the write of an in-flight access.
  assign done     = complete && reset;
  assign StallMem = stall && reset;
  assign wr_en    = done && !acc_err && MemWriteM;

  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{ALUOutM[1:0], 3'b000} +: 8];

  always_comb begin
    ReadDataM = 32'h0;
    if (done && !acc_err && !MemWriteM) begin
      ReadDataM = ByteM ? {24'h0, rd_byte} : rd_word;
    end
  end

  assign MemErrM = done && acc_err;

  assign access_cnt_d = (done && !acc_err && access_cnt_q != 16'hFFFF)
                        ? access_cnt_q + 16'd1 : access_cnt_q;
  assign AccessCount  = access_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      access_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      access_cnt_q <= access_cnt_d;
    end
  end

  assign byte_en = ByteM ? (4'b0001 << ALUOutM[1:0]) : 4'b1111;
  assign wr_data = ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;

  // NOTE: the RAM array has no reset; its contents survive reset and it maps
  // onto plain memory macros.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of accesses on a LATENCY=2 instance plus
// abort, reset, saturation and zero-latency sequences.
module tb_dmem_responder;

  typedef struct {
    logic        wr;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, byt = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, err;
  logic [15:0] count;

  logic        rst0_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, byt0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [31:0] rdata0;
  logic        stall0, err0;
  logic [15:0] count0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(rst_n), .MemReqM(req), .MemWriteM(we), .ByteM(byt),
    .ALUOutM(addr), .WriteDataM(wdata), .ReadDataM(rdata), .StallMem(stall),
    .MemErrM(err), .AccessCount(count)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst0_n), .MemReqM(req0), .MemWriteM(we0), .ByteM(byt0),
    .ALUOutM(addr0), .WriteDataM(wdata0), .ReadDataM(rdata0), .StallMem(stall0),
    .MemErrM(err0), .AccessCount(count0)
  );

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  vec_t        vecs[$];
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full access on the LATENCY=2 instance; expectation goes through the scoreboard.
  task automatic access(input vec_t v);
    int   stalls;
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = v.wr; byt = v.byt; addr = v.addr; wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    stalls = 0;
    #1;
    while (stall && stalls < 10) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check($sformatf("stall_cycles@%h", v.addr), 32'(stalls), 32'd2);
    e = sb.pop_front();
    check($sformatf("rdata@%h", v.addr), rdata, e.rdata);
    check($sformatf("err@%h", v.addr), {31'b0, err}, {31'b0, e.err});
    @(posedge clk);
    #1;
    if (!v.exp_err && exp_count != 16'hFFFF) exp_count++;
    check($sformatf("count@%h", v.addr), {16'b0, count}, {16'b0, exp_count});
  endtask

  task automatic go_idle();
    @(negedge clk);
    req = 1'b0;
  endtask

  logic [31:0] vals0 [3];
  exp_t        e0;

  initial begin
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h12345678, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h21,       32'h0,        32'h00000056, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h23,       32'h0,        32'h00000012, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h22,       32'hFFFFFFAA, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h20,       32'h0,        32'h12AA5678, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00,       32'h0BADF00D, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h06,       32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h100,      32'hCAFEF00D, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h00,       32'h0,        32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'h0,        32'h000000EF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h11,       32'h00000077, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEAD77EF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFC,       32'h600DCAFE, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFC,       32'h0,        32'h600DCAFE, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFF,       32'h0,        32'h00000060, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h100,      32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h22,       32'h55555555, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h20,       32'h0,        32'h12AA5678, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h30,       32'h11111111, 32'h0,        1'b0});

    // Reset holds outputs low even with a request pending.
    req = 1'b1; addr = 32'h10;
    #12;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_count", {16'b0, count}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1; rst0_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) access(vecs[i]);
    go_idle();

    // Abort: drop the request while BUSY with cnt=1; the store must not land.
    @(negedge clk);
    req = 1'b1; we = 1'b1; byt = 1'b0; addr = 32'h30; wdata = 32'h22222222;
    #1 check("abort_stall_first", {31'b0, stall}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    #1;
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 check("abort_count", {16'b0, count}, {16'b0, exp_count});
    access('{1'b0, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0});
    go_idle();

    // Reset pulled low in the completion cycle of a store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; byt = 1'b0; addr = 32'h30; wdata = 32'h33333333;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1 check("midrst_count", {16'b0, count}, 32'd0);
    exp_count = 16'd0;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    access('{1'b0, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0});
    go_idle();

    // Saturation of AccessCount.
    @(negedge clk);
    force u_dut.access_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u_dut.access_cnt_q;
    exp_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) access('{1'b0, 1'b0, 32'h20, 32'h0, 32'h12AA5678, 1'b0});
    go_idle();

    // Zero latency: stores, a reset (RAM survives), then three back-to-back loads.
    vals0[0] = 32'hA5A5A5A5; vals0[1] = 32'h01234567; vals0[2] = 32'h89ABCDEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; byt0 = 1'b0; addr0 = 32'(4 * i); wdata0 = vals0[i];
      #1 check("lat0_store_stall", {31'b0, stall0}, 32'd0);
    end
    @(negedge clk);
    req0 = 1'b0;
    rst0_n = 1'b0;
    #1 check("lat0_rst_count", {16'b0, count0}, 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; byt0 = 1'b0; addr0 = 32'(4 * i);
      sb.push_back('{vals0[i], 1'b0});
      #1;
      e0 = sb.pop_front();
      check("lat0_stall", {31'b0, stall0}, 32'd0);
      check("lat0_rdata", rdata0, e0.rdata);
      check("lat0_err", {31'b0, err0}, {31'b0, e0.err});
      @(posedge clk);
      #1 check("lat0_count", {16'b0, count0}, 32'(i + 1));
    end
    @(negedge clk);
    req0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
